// File: rtl/tx_scheduler.sv
// tx_scheduler: ping-pong message RAM manager and frame sequencer for signal_gen.
// The host fills one bank while the generator plays the other; frames are
// separated by a programmable idle gap and can be aborted mid-flight.
module tx_scheduler #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [7:0]        host_wr_data,
    input  logic              host_commit,
    output logic              host_ready,
    output logic              host_overrun,
    input  logic [CNT_W-1:0]  gap_cycles,
    input  logic              abort,
    input  logic              dac_ready,
    output logic              gen_enable,
    output logic              gen_reset,
    input  logic              gen_done,
    input  logic              gen_read_enable,
    input  logic [ADDR_W-1:0] gen_ram_addr,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic              ram_re,
    output logic [ADDR_W:0]   ram_raddr,
    output logic [CNT_W-1:0]  frames_sent,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        ACK   = 3'd3,
        GAP   = 3'd4,
        ABORT = 3'd5
    } state_t;

    state_t           state;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [1:0]       full_next;
    logic [CNT_W-1:0] gap_cnt;
    logic             commit_ok;
    logic             rd_free;

    // Host side: fill bank is writable while it is not waiting to be played
    assign host_ready = !reset_n || !full[wr_bank];
    assign ram_we     = host_wr_en & host_ready;
    assign ram_waddr  = {wr_bank, host_wr_addr};
    assign ram_wdata  = host_wr_data;
    assign commit_ok  = host_commit & host_ready;

    // Generator side: read port is a straight pass-through into the play bank
    assign ram_re    = gen_read_enable;
    assign ram_raddr = {rd_bank, gen_ram_addr};

    // Bank release happens on completion or abort of the current frame
    assign rd_free = (state == ACK) || (state == ABORT);

    // Output decode from state; reset forces the generator quiet and held in reset
    always_comb begin
        gen_enable = 1'b0;
        unique case (state)
            START:   gen_enable = 1'b1;
            RUN:     gen_enable = dac_ready;
            ACK:     gen_enable = 1'b1;
            default: gen_enable = 1'b0;
        endcase
        gen_enable = gen_enable & reset_n;
    end

    assign gen_reset = !reset_n || (state == ABORT);
    assign busy      = reset_n && (state != IDLE);

    // Set and clear target different banks, so both may apply in one cycle
    always_comb begin
        full_next = full;
        if (rd_free)
            full_next[rd_bank] = 1'b0;
        if (commit_ok)
            full_next[wr_bank] = 1'b1;
    end

    // Bank bookkeeping, overrun flag and frame sequencing FSM
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            full         <= '0;
            host_overrun <= 1'b0;
            frames_sent  <= '0;
            gap_cnt      <= '0;
        end else begin
            full <= full_next;
            if (commit_ok)
                wr_bank <= ~wr_bank;
            if (rd_free)
                rd_bank <= ~rd_bank;
            if ((host_wr_en || host_commit) && !host_ready)
                host_overrun <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (full[rd_bank])
                        state <= START;
                end
                START: begin
                    state <= abort ? ABORT : RUN;
                end
                RUN: begin
                    if (abort)
                        state <= ABORT;
                    else if (gen_done)
                        state <= ACK;
                end
                ACK: begin
                    frames_sent <= frames_sent + CNT_W'(1);
                    gap_cnt     <= gap_cycles;
                    state       <= (gap_cycles != '0) ? GAP : IDLE;
                end
                GAP: begin
                    gap_cnt <= gap_cnt - CNT_W'(1);
                    if (gap_cnt <= CNT_W'(1))
                        state <= IDLE;
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: scenario tasks with a bank scoreboard and a small bank model.
module tb_tx_scheduler;

    localparam int AW = 10;
    localparam int CW = 16;

    logic          clk;
    logic          reset_n;
    logic          host_wr_en;
    logic [AW-1:0] host_wr_addr;
    logic [7:0]    host_wr_data;
    logic          host_commit;
    logic          host_ready;
    logic          host_overrun;
    logic [CW-1:0] gap_cycles;
    logic          abort;
    logic          dac_ready;
    logic          gen_enable;
    logic          gen_reset;
    logic          gen_done;
    logic          gen_read_enable;
    logic [AW-1:0] gen_ram_addr;
    logic          ram_we;
    logic [AW:0]   ram_waddr;
    logic [7:0]    ram_wdata;
    logic          ram_re;
    logic [AW:0]   ram_raddr;
    logic [CW-1:0] frames_sent;
    logic          busy;

    tx_scheduler #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data), .host_commit(host_commit),
        .host_ready(host_ready), .host_overrun(host_overrun),
        .gap_cycles(gap_cycles), .abort(abort), .dac_ready(dac_ready),
        .gen_enable(gen_enable), .gen_reset(gen_reset), .gen_done(gen_done),
        .gen_read_enable(gen_read_enable), .gen_ram_addr(gen_ram_addr),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr),
        .frames_sent(frames_sent), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    bit            exp_q[$];
    bit [1:0]      m_full;
    bit            m_wr;
    bit            m_rd;
    bit            m_overrun;
    logic [CW-1:0] exp_frames;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_full = 2'b00; m_wr = 1'b0; m_rd = 1'b0; m_overrun = 1'b0;
        exp_frames = '0;
        exp_q.delete();
    endtask

    // Fill four bytes of the current fill bank and commit it
    task automatic fill_commit();
        logic [AW:0] exp_a;
        for (int i = 0; i < 4; i++) begin
            host_wr_en = 1'b1; host_wr_addr = AW'(i + 8); host_wr_data = 8'(8'hA0 + i);
            #1;
            exp_a = {m_wr, AW'(i + 8)};
            checks++;
            if (ram_we !== !m_full[m_wr] || ram_waddr !== exp_a || ram_wdata !== 8'(8'hA0 + i)) begin
                errors++;
                $display("FAIL fill_write%0d we=%b waddr=%h wdata=%h expected we=%b waddr=%h wdata=%h",
                         i, ram_we, ram_waddr, ram_wdata, !m_full[m_wr], exp_a, 8'(8'hA0 + i));
            end
            cyc();
        end
        host_wr_en = 1'b0;
        host_commit = 1'b1;
        cyc();
        host_commit = 1'b0;
        if (!m_full[m_wr]) begin
            exp_q.push_back(m_wr);
            m_full[m_wr] = 1'b1;
            m_wr = ~m_wr;
        end else begin
            m_overrun = 1'b1;
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL start_timeout busy=%b expected 1 within 20 cycles", busy);
        end
    endtask

    // Play one frame from START through ACK/GAP or ABORT back to IDLE
    task automatic run_frame(input bit do_abort, input int gap, input bit toggle_dac,
                             input bit fill_during_run);
        bit          ok;
        bit          b;
        int          cnt;
        bit          en_bad;
        logic [AW:0] exp_a;
        gap_cycles = CW'(gap);
        wait_start(ok);
        if (!ok) return;
        checks++;
        if (gen_enable !== 1'b1 || gen_reset !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse gen_enable=%b gen_reset=%b expected 1 0", gen_enable, gen_reset);
        end
        cyc();
        b = 1'b0;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty frame started with no committed bank expected");
        end else begin
            b = exp_q.pop_front();
        end
        gen_read_enable = 1'b1; gen_ram_addr = AW'(5);
        #1;
        exp_a = {b, AW'(5)};
        checks++;
        if (ram_re !== 1'b1 || ram_raddr !== exp_a || gen_enable !== dac_ready) begin
            errors++;
            $display("FAIL run_read re=%b raddr=%h gen_enable=%b expected 1 %h %b",
                     ram_re, ram_raddr, gen_enable, exp_a, dac_ready);
        end
        gen_read_enable = 1'b0;
        if (toggle_dac) begin
            for (int i = 0; i < 4; i++) begin
                dac_ready = i[0];
                #1;
                checks++;
                if (gen_enable !== i[0]) begin
                    errors++;
                    $display("FAIL dac_mirror%0d gen_enable=%b expected %b", i, gen_enable, i[0]);
                end
                cyc();
            end
            dac_ready = 1'b1;
        end
        if (fill_during_run) begin
            fill_commit();
            checks++;
            if (host_ready !== !m_full[m_wr]) begin
                errors++;
                $display("FAIL both_full_ready host_ready=%b expected %b", host_ready, !m_full[m_wr]);
            end
            host_wr_en = 1'b1; host_wr_addr = AW'(3); host_commit = 1'b1;
            #1;
            checks++;
            if (ram_we !== 1'b0) begin
                errors++;
                $display("FAIL overrun_drop ram_we=%b expected 0", ram_we);
            end
            m_overrun = 1'b1;
            cyc();
            host_wr_en = 1'b0; host_commit = 1'b0;
            checks++;
            if (host_overrun !== 1'b1 || host_ready !== 1'b0) begin
                errors++;
                $display("FAIL overrun_flag overrun=%b host_ready=%b expected 1 0", host_overrun, host_ready);
            end
        end
        gen_done = 1'b1; abort = do_abort;
        cyc();
        gen_done = 1'b0; abort = 1'b0;
        if (do_abort) begin
            checks++;
            if (gen_reset !== 1'b1 || gen_enable !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL abort_state gen_reset=%b gen_enable=%b busy=%b expected 1 0 1",
                         gen_reset, gen_enable, busy);
            end
            cyc();
            checks++;
            if (busy !== 1'b0 || gen_reset !== 1'b0 || frames_sent !== exp_frames) begin
                errors++;
                $display("FAIL abort_done busy=%b gen_reset=%b frames=%0d expected 0 0 %0d",
                         busy, gen_reset, frames_sent, exp_frames);
            end
        end else begin
            checks++;
            if (gen_enable !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ack_pulse gen_enable=%b busy=%b expected 1 1", gen_enable, busy);
            end
            exp_frames = exp_frames + CW'(1);
            cnt = 0;
            en_bad = 1'b0;
            for (int i = 0; i < 200; i++) begin
                cyc();
                if (busy !== 1'b1) break;
                cnt++;
                if (gen_enable !== 1'b0) en_bad = 1'b1;
                if (cnt == 1) gap_cycles = CW'(gap + 5);
            end
            checks++;
            if (cnt != gap || en_bad || frames_sent !== exp_frames) begin
                errors++;
                $display("FAIL gap_len gap=%0d en_in_gap=%b frames=%0d expected gap=%0d en_in_gap=0 frames=%0d",
                         cnt, en_bad, frames_sent, gap, exp_frames);
            end
        end
        m_full[m_rd] = 1'b0;
        m_rd = ~m_rd;
        checks++;
        if (host_ready !== !m_full[m_wr] || host_overrun !== m_overrun) begin
            errors++;
            $display("FAIL frame_end host_ready=%b overrun=%b expected %b %b",
                     host_ready, host_overrun, !m_full[m_wr], m_overrun);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(); cyc();
        checks++;
        if (gen_enable !== 1'b0 || busy !== 1'b0 || host_ready !== 1'b1 || gen_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs en=%b busy=%b ready=%b gen_reset=%b expected 0 0 1 1",
                     gen_enable, busy, host_ready, gen_reset);
        end
        reset_n = 1'b1;
        cyc();
        model_reset();
        checks++;
        if (frames_sent !== '0 || host_overrun !== 1'b0 || busy !== 1'b0 || gen_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_state frames=%0d overrun=%b busy=%b gen_reset=%b expected 0 0 0 0",
                     frames_sent, host_overrun, busy, gen_reset);
        end
    endtask

    task automatic test_basic_frame();
        fill_commit();
        run_frame(1'b0, 3, 1'b0, 1'b0);
    endtask

    task automatic test_dac_gap0();
        fill_commit();
        run_frame(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        fill_commit();
        run_frame(1'b1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_commit();
        run_frame(1'b0, 2, 1'b0, 1'b1);
        run_frame(1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit still_idle;
        fill_commit();
        fill_commit();
        wait_start(ok);
        cyc();
        reset_n = 1'b0; host_wr_en = 1'b1; host_wr_addr = AW'(1);
        #1;
        checks++;
        if (gen_enable !== 1'b0 || busy !== 1'b0 || host_ready !== 1'b1 ||
            gen_reset !== 1'b1 || ram_we !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset en=%b busy=%b ready=%b gen_reset=%b we=%b expected 0 0 1 1 1",
                     gen_enable, busy, host_ready, gen_reset, ram_we);
        end
        cyc();
        reset_n = 1'b1; host_wr_en = 1'b0;
        model_reset();
        #1;
        checks++;
        if (frames_sent !== '0 || host_overrun !== 1'b0 || busy !== 1'b0 || host_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_state frames=%0d overrun=%b busy=%b ready=%b expected 0 0 0 1",
                     frames_sent, host_overrun, busy, host_ready);
        end
        still_idle = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (busy !== 1'b0) still_idle = 1'b0;
        end
        checks++;
        if (!still_idle) begin
            errors++;
            $display("FAIL banks_discarded busy_seen=1 expected 0");
        end
        fill_commit();
        run_frame(1'b0, 2, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        host_commit = 1'b0; gap_cycles = '0; abort = 1'b0; dac_ready = 1'b1;
        gen_done = 1'b0; gen_read_enable = 1'b0; gen_ram_addr = '0;
        model_reset();
        test_reset();
        test_basic_frame();
        test_dac_gap0();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
